// File: rtl/vga_pkg.sv
// Shared screen geometry and the packed pixel record stored by the clip queue.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Circular pixel buffer: DEPTH entries (power of 2), wrapping pointers, occupancy count.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_push,
    input  pixel_t i_din,
    input  logic   i_pop,
    output pixel_t o_dout,
    output logic   o_full,
    output logic   o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    pixel_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_clip_queue.sv
// Clips signed pixel requests to the visible screen, queues on-screen ones, plots one per cycle.
// Optional PIXEL_STATS_EN adds saturating plotted/clipped pixel counters.
module pixel_clip_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int          SCREEN_W = vga_pkg::SCREEN_W,
    parameter int          SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_x,
    input  logic [7:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        out_ready,
    output logic [7:0]  out_x,
    output logic [6:0]  out_y,
    output logic [2:0]  out_colour,
    output logic        out_plot,
`ifdef PIXEL_STATS_EN
    output logic [15:0] plotted_cnt,
    output logic [15:0] clipped_cnt,
`endif
    output logic        empty
);

    import vga_pkg::*;

    logic   w_accept;
    logic   w_on_screen;
    logic   w_push;
    logic   w_pop;
    logic   w_full;
    logic   w_fifo_empty;
    pixel_t w_din;
    pixel_t w_head;
    pixel_t r_out;
    logic   r_plot;

    // Sign bit clear means the zero-extended value equals the signed one, so the
    // upper-bound compare runs on the full width without truncation.
    assign w_on_screen = !in_x[8] && (int'(in_x) < SCREEN_W) &&
                         !in_y[7] && (int'(in_y) < SCREEN_H);

    assign in_ready = !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_on_screen;
    assign w_pop    = !w_fifo_empty && out_ready;
    assign w_din    = '{x: in_x[7:0], y: in_y[6:0], colour: in_colour};

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_plot <= 1'b0;
        end else begin
            r_plot <= w_pop;
            if (w_pop) begin
                r_out <= w_head;
            end
        end
    end

    assign out_x      = r_out.x;
    assign out_y      = r_out.y;
    assign out_colour = r_out.colour;
    assign out_plot   = r_plot;
    assign empty      = w_fifo_empty && !r_plot;

`ifdef PIXEL_STATS_EN
    logic [15:0] r_plotted_cnt;
    logic [15:0] r_clipped_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_plotted_cnt <= '0;
            r_clipped_cnt <= '0;
        end else begin
            if (w_pop && (r_plotted_cnt != '1)) begin
                r_plotted_cnt <= r_plotted_cnt + 1'b1;
            end
            if (w_accept && !w_on_screen && (r_clipped_cnt != '1)) begin
                r_clipped_cnt <= r_clipped_cnt + 1'b1;
            end
        end
    end

    assign plotted_cnt = r_plotted_cnt;
    assign clipped_cnt = r_clipped_cnt;
`endif

endmodule
